seg_scan_driver: RTL
====================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL provide parameter NUM_DIGITS, default 4, number of multiplexed digits, legal range 1..8.
REQ-002 SHALL provide parameter VALUE_W, default 14, binary input width, legal range 4..27.
REQ-003 SHALL provide parameter SEG_ACTIVE_LOW, default 1; 1 = segment lit when bit is 0.
REQ-004 SHALL provide parameter AN_ACTIVE_LOW, default 1; 1 = digit enabled when anode bit is 0.
REQ-005 SHALL provide clk  input  1  clock; all state on rising edge.
REQ-006 SHALL provide rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL provide scan_tick  input  1  one-cycle enable advancing digit scan.
REQ-008 SHALL provide load  input  1  one-cycle request to convert value.
REQ-009 SHALL provide value  input  VALUE_W  unsigned binary number to display.
REQ-010 SHALL provide an  output  NUM_DIGITS  registered one-hot digit enable, polarity per AN_ACTIVE_LOW.
REQ-011 SHALL provide seg  output  7  registered segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
REQ-012 SHALL provide busy  output  1  high while conversion in progress.
REQ-013 SHALL provide overflow  output  1  high when displayed value >= 10^NUM_DIGITS.

Function
REQ-014 SHALL implement FSM IDLE -> CONV -> COMMIT -> IDLE; load in IDLE captures value and enters CONV next cycle.
REQ-015 SHALL convert in CONV by sequential double-dabble, one bit per cycle, exactly VALUE_W cycles, BCD width 4*NUM_DIGITS plus carry-out detection.
REQ-016 SHALL, in COMMIT, write BCD digits and overflow into display registers in one cycle; display update latency = VALUE_W+2 cycles after load cycle.
REQ-017 SHALL hold busy high in CONV and COMMIT, low in IDLE; load while busy is ignored, no queueing.
REQ-018 SHALL set overflow when value >= 10^NUM_DIGITS; while overflow, every digit shows dash (g only).
REQ-019 SHALL keep a scan index 0..NUM_DIGITS-1, incremented on scan_tick, wrapping NUM_DIGITS-1 -> 0; no change without scan_tick.
REQ-020 SHALL update an and seg on the cycle after scan_tick (one-cycle registered latency); index 0 = least significant digit.
REQ-021 SHALL encode active-high patterns 0..9: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111; blank = 0000000; invert when SEG_ACTIVE_LOW.
REQ-022 SHALL let scanning continue uninterrupted during conversion, showing previously committed digits.
REQ-023 SHALL treat scan_tick and load in the same cycle independently.

Reset
REQ-024 SHALL on rst clear FSM to IDLE, busy=0, overflow=0, scan index=0, display digits=0.
REQ-025 SHALL on rst drive an = digit 0 enabled, seg = pattern '0' (subject to polarity); rst mid-conversion discards the conversion.

Configuration
REQ-026 SHALL honour macro SEG_LZB_EN: when defined, digits above the most significant nonzero digit are blank; digit 0 always shown; overflow dashes unaffected.
REQ-027 SHALL, without SEG_LZB_EN, display all NUM_DIGITS digits including leading zeros.

Verification (NUM_DIGITS=4, VALUE_W=14, both polarities active-low)
REQ-028 SHALL check: load value=1234 -> busy high 15 cycles, then with scan_tick digits 0..3 show seg 0011001, 0110000, 0100100, 1111001.
REQ-029 SHALL check: load value=10000 -> overflow=1, all four digits seg=0111111.
REQ-030 SHALL check: load 42 then load 99 two cycles later -> second ignored, display shows 42.
REQ-031 SHALL check: 5 scan_ticks from reset -> an sequence 1101, 1011, 0111, 1110, 1101.
REQ-032 SHALL check: load 7 -> with SEG_LZB_EN digits 1..3 seg=1111111; without, seg=1000000.
REQ-033 SHALL check: rst asserted mid-CONV of 9999 -> busy=0, all digits show 0, an=1110.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment driver: sequential double-dabble binary-to-BCD conversion plus a digit scanner.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_driver #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned VALUE_W        = 14,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_tick,
    input  logic                  load,
    input  logic [VALUE_W-1:0]    value,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  busy,
    output logic                  overflow
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(VALUE_W + 1);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [6:0] PAT_ZERO = 7'b0111111;
    localparam logic [6:0] PAT_DASH = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             capture_c, shift_c, commit_c;
    logic [VALUE_W-1:0] bin_q;
    logic [BCD_W-1:0] bcd_q, bcd_adj, disp_q;
    logic             ovf_acc;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q, idx_nxt;

    function automatic logic [6:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    encode = 7'b0111111;
            4'd1:    encode = 7'b0000110;
            4'd2:    encode = 7'b1011011;
            4'd3:    encode = 7'b1001111;
            4'd4:    encode = 7'b1100110;
            4'd5:    encode = 7'b1101101;
            4'd6:    encode = 7'b1111101;
            4'd7:    encode = 7'b0000111;
            4'd8:    encode = 7'b1111111;
            4'd9:    encode = 7'b1101111;
            default: encode = 7'b0000000;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = CONV;
            CONV:    if (cnt_q == CNT_W'(VALUE_W - 1)) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control decode
    always_comb begin
        capture_c = 1'b0;
        shift_c   = 1'b0;
        commit_c  = 1'b0;
        case (state)
            IDLE:    capture_c = load;
            CONV:    shift_c   = 1'b1;
            COMMIT:  commit_c  = 1'b1;
            default: ;
        endcase
    end

    // Add-3 adjust of every BCD digit before the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Conversion datapath; a bit shifted out of the top digit means the value needs more digits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_acc <= 1'b0;
            cnt_q   <= '0;
        end else if (capture_c) begin
            bin_q   <= value;
            bcd_q   <= '0;
            ovf_acc <= 1'b0;
            cnt_q   <= '0;
        end else if (shift_c) begin
            bin_q   <= {bin_q[VALUE_W-2:0], 1'b0};
            bcd_q   <= {bcd_adj[BCD_W-2:0], bin_q[VALUE_W-1]};
            ovf_acc <= ovf_acc | bcd_adj[BCD_W-1];
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q   <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            if (commit_c) begin
                disp_q   <= bcd_q;
                overflow <= ovf_acc;
            end
        end
    end

    // Scan index
    always_comb begin
        idx_nxt = idx_q;
        if (scan_tick) begin
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) idx_nxt = '0;
            else                                 idx_nxt = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) idx_q <= '0;
        else     idx_q <= idx_nxt;
    end

    logic [NUM_DIGITS-1:0] blank_mask;
    logic                  nz_above;
    logic [3:0]            dig_sel;
    logic                  blank_sel;
    logic [6:0]            pat;
    logic [NUM_DIGITS-1:0] an_oh;

    // Digits above the most significant nonzero digit are blank; digit 0 never is
    always_comb begin
        blank_mask = '0;
        nz_above   = 1'b0;
`ifdef SEG_LZB_EN
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            nz_above      = nz_above | (disp_q[4*i +: 4] != 4'd0);
            blank_mask[i] = ~nz_above;
        end
`endif
    end

    always_comb begin
        dig_sel   = 4'd0;
        blank_sel = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                dig_sel   = disp_q[4*i +: 4];
                blank_sel = blank_mask[i];
            end
        end
        if (overflow)       pat = PAT_DASH;
        else if (blank_sel) pat = 7'b0000000;
        else                pat = encode(dig_sel);
        an_oh = NUM_DIGITS'(1) << idx_nxt;
    end

    // Display outputs follow the scan index one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= (AN_ACTIVE_LOW != 0) ? ~NUM_DIGITS'(1) : NUM_DIGITS'(1);
            seg <= (SEG_ACTIVE_LOW != 0) ? ~PAT_ZERO : PAT_ZERO;
        end else begin
            an  <= (AN_ACTIVE_LOW != 0) ? ~an_oh : an_oh;
            seg <= (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
        end
    end

endmodule
